// File: rtl/vga_fetch_ctrl_if.sv
// AXI4 read-address / read-data channel bundle for the VGA frame fetcher.
// The master modport is the fetch controller; the slave modport is the
// interconnect side. Signal names keep the controller's point of view.
interface vga_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  arvalid_o;
  logic                  arready_i;
  logic [ADDR_WIDTH-1:0] araddr_o;
  logic [7:0]            arlen_o;
  logic [1:0]            arburst_o;
  logic [2:0]            arsize_o;
  logic                  rvalid_i;
  logic [1:0]            rresp_i;
  logic                  rlast_i;
  logic                  rready_o;

  modport master (
    output arvalid_o, araddr_o, arlen_o, arburst_o, arsize_o, rready_o,
    input  arready_i, rvalid_i, rresp_i, rlast_i
  );

  modport slave (
    input  arvalid_o, araddr_o, arlen_o, arburst_o, arsize_o, rready_o,
    output arready_i, rvalid_i, rresp_i, rlast_i
  );
endinterface

// File: rtl/vga_fetch_ctrl.sv
// vga_fetch_ctrl: burst scheduler for the VGA frame-fetch path (AXI domain).
// Keeps fill state of the ping/pong halves of the line buffer, issues one
// INCR read burst per empty half while walking base..top with wrap, steers
// returned beats into the buffer and flags underrun and bus errors.
// Optional feature macro: VGA_FETCH_RETRY_EN (re-issue a burst that saw an
// error response, up to three retries, before accepting the half anyway).
module vga_fetch_ctrl #(
  parameter  int ADDR_WIDTH = 64,
  parameter  int DATA_WIDTH = 64,
  parameter  int BURST_LEN  = 32,
  localparam int IW         = $clog2(BURST_LEN)
) (
  input  logic                  clk_a,
  input  logic                  resetn_a,
  input  logic                  enable_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] top_addr_i,
  input  logic                  release_i,
  input  logic                  release_half_i,
  vga_fetch_ctrl_if.master      axi,
  output logic                  wr_en_o,
  output logic                  wr_half_o,
  output logic [IW-1:0]         wr_idx_o,
  output logic [1:0]            full_o,
  output logic                  underrun_o,
  output logic                  err_o
);

  localparam int              BB       = DATA_WIDTH / 8;
  localparam int              SIZE_ENC = $clog2(BB);
  localparam logic [IW-1:0]   LAST_IDX = IW'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH:0] STEP = (ADDR_WIDTH + 1)'(BURST_LEN * BB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [ADDR_WIDTH-1:0] r_curAddr;
  logic                  r_fillHalf;
  logic [IW-1:0]         r_beatCnt;
  logic [1:0]            r_full;
  logic                  r_burstErr;
  logic                  r_underrun;
  logic                  r_err;

  logic                  w_arvalid;
  logic                  w_rready;
  logic                  w_beat;
  logic                  w_lastBeat;
  logic                  w_beatErr;
  logic                  w_lastErr;
  logic                  w_burstErrNow;
  logic                  w_commit;
  logic                  w_idleClear;
  logic [ADDR_WIDTH:0]   w_sum;
  logic [ADDR_WIDTH-1:0] w_nextAddr;
  logic [1:0]            w_fullNext;

  // Beat qualification and error detection; rlast is only cross-checked
  // against the beat counter, the counter alone decides where a burst ends.
  assign w_beat        = (r_state == DATA) && axi.rvalid_i;
  assign w_lastBeat    = w_beat && (r_beatCnt == LAST_IDX);
  assign w_beatErr     = w_beat && (axi.rresp_i != 2'b00);
  assign w_lastErr     = w_beat && (axi.rlast_i != (r_beatCnt == LAST_IDX));
  assign w_burstErrNow = r_burstErr | w_beatErr;
  assign w_idleClear   = (r_state == IDLE) && !enable_i;

  // Next frame address, compared one bit wider so a top near the end of the
  // address space still wraps instead of overflowing.
  assign w_sum      = {1'b0, r_curAddr} + STEP;
  assign w_nextAddr = (w_sum >= {1'b0, top_addr_i}) ? base_addr_i : w_sum[ADDR_WIDTH-1:0];

`ifdef VGA_FETCH_RETRY_EN
  logic [1:0] r_retryCnt;
  logic       w_retry;

  // A failed burst is retried at the same address until three retries have
  // been spent; after that the half is accepted as-is.
  assign w_retry  = w_lastBeat && w_burstErrNow && (r_retryCnt != 2'd3);
  assign w_commit = w_lastBeat && !w_retry;

  // Retry counter: counts consecutive failed attempts on the current half.
  always_ff @(posedge clk_a) begin
    if (!resetn_a) begin
      r_retryCnt <= 2'd0;
    end else if (w_idleClear || w_commit) begin
      r_retryCnt <= 2'd0;
    end else if (w_retry) begin
      r_retryCnt <= r_retryCnt + 2'd1;
    end
  end
`else
  // Without retry, error beats are simply dropped and the half still counts as filled.
  assign w_commit = w_lastBeat;
`endif

  // Full flags: a release clears, a completed fill sets and wins over a
  // release of the same half, and disabling the fetcher empties everything.
  always_comb begin
    w_fullNext = r_full;
    if (release_i) begin
      w_fullNext[release_half_i] = 1'b0;
    end
    if (w_commit) begin
      w_fullNext[r_fillHalf] = 1'b1;
    end
    if (w_idleClear) begin
      w_fullNext = 2'b00;
    end
  end

  // Next-state and handshake outputs of the burst FSM.
  always_comb begin
    w_stateNext = r_state;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable_i && !r_full[r_fillHalf]) begin
          w_stateNext = ADDR;
        end
      end
      ADDR: begin
        w_arvalid = 1'b1;
        if (axi.arready_i) begin
          w_stateNext = DATA;
        end
      end
      DATA: begin
        w_rready = 1'b1;
        if (w_lastBeat) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_a) begin
    if (!resetn_a) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Address walk, fill bookkeeping, beat counting and sticky status flags.
  always_ff @(posedge clk_a) begin
    if (!resetn_a) begin
      r_curAddr  <= '0;
      r_fillHalf <= 1'b0;
      r_beatCnt  <= '0;
      r_full     <= 2'b00;
      r_burstErr <= 1'b0;
      r_underrun <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_full <= w_fullNext;
      if (release_i && !r_full[release_half_i]) begin
        r_underrun <= 1'b1;
      end
      if (w_beatErr || w_lastErr) begin
        r_err <= 1'b1;
      end
      if (w_idleClear) begin
        r_curAddr  <= base_addr_i;
        r_fillHalf <= 1'b0;
      end
      if ((r_state == ADDR) && axi.arready_i) begin
        r_beatCnt  <= '0;
        r_burstErr <= 1'b0;
      end
      if (w_beat) begin
        r_beatCnt <= r_beatCnt + 1'b1;
      end
      if (w_beatErr) begin
        r_burstErr <= 1'b1;
      end
      if (w_commit) begin
        r_fillHalf <= ~r_fillHalf;
        r_curAddr  <= w_nextAddr;
      end
    end
  end

  assign axi.arvalid_o = w_arvalid;
  assign axi.araddr_o  = r_curAddr;
  assign axi.arlen_o   = 8'(BURST_LEN - 1);
  assign axi.arburst_o = 2'b01;
  assign axi.arsize_o  = 3'(SIZE_ENC);
  assign axi.rready_o  = w_rready;

  assign wr_en_o    = w_beat && (axi.rresp_i == 2'b00);
  assign wr_half_o  = r_fillHalf;
  assign wr_idx_o   = r_beatCnt;
  assign full_o     = r_full;
  assign underrun_o = r_underrun;
  assign err_o      = r_err;

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Testbench for vga_fetch_ctrl: randomized AXI slave behaviour with a
// burst-level reference model and a scoreboard of expected AR addresses and
// buffer writes that a separate monitor process checks.
module tb_vga_fetch_ctrl;

  localparam int     AW   = 64;
  localparam int     DW   = 64;
  localparam int     BL   = 32;
  localparam int     IW   = 5;
  localparam longint STEP = BL * DW / 8;

  logic          clk_a = 1'b0;
  logic          resetn_a;
  logic          enable_i;
  logic [AW-1:0] base_addr_i;
  logic [AW-1:0] top_addr_i;
  logic          release_i;
  logic          release_half_i;
  logic          wr_en_o;
  logic          wr_half_o;
  logic [IW-1:0] wr_idx_o;
  logic [1:0]    full_o;
  logic          underrun_o;
  logic          err_o;

  vga_fetch_ctrl_if #(.ADDR_WIDTH(AW)) axi ();

  vga_fetch_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk_a         (clk_a),
    .resetn_a      (resetn_a),
    .enable_i      (enable_i),
    .base_addr_i   (base_addr_i),
    .top_addr_i    (top_addr_i),
    .release_i     (release_i),
    .release_half_i(release_half_i),
    .axi           (axi),
    .wr_en_o       (wr_en_o),
    .wr_half_o     (wr_half_o),
    .wr_idx_o      (wr_idx_o),
    .full_o        (full_o),
    .underrun_o    (underrun_o),
    .err_o         (err_o)
  );

  always #5 clk_a = ~clk_a;

  int testsRun = 0;
  int testsFailed = 0;

  // Scoreboard queues filled by stimulus, drained by the monitor.
  logic [AW-1:0] arQ[$];
  logic [IW:0]   wrQ[$];

  // Reference model: burst-level view of the frame walk and buffer halves.
  longint mBase;
  longint mTop;
  int     mIdx;
  bit     mHalf;
  bit [1:0] mFull;
  bit     mUnder;
  bit     mErr;
  int     mRetry;

  function automatic logic [AW-1:0] modelAddr();
    longint n;
    n = (mTop - mBase + STEP - 1) / STEP;
    return AW'(mBase + longint'(mIdx % n) * STEP);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  // Monitor: compares every AR handshake and every buffer write with the scoreboard.
  logic [AW-1:0] expAddr;
  logic [IW:0]   expWr;
  initial begin
    forever begin
      @(negedge clk_a);
      if (resetn_a === 1'b1) begin
        if (axi.arvalid_o && axi.arready_i) begin
          if (arQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpectedAR: got addr 0x%0h expected no request", axi.araddr_o);
          end else begin
            expAddr = arQ.pop_front();
            checkOutput("araddr", axi.araddr_o, expAddr);
          end
          checkOutput("arlen", axi.arlen_o, 64'd31);
          checkOutput("arburst", axi.arburst_o, 64'd1);
          checkOutput("arsize", axi.arsize_o, 64'd3);
        end
        if (wr_en_o) begin
          if (wrQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpectedWrite: got half %0d idx %0d expected no write", wr_half_o, wr_idx_o);
          end else begin
            expWr = wrQ.pop_front();
            checkOutput("wrTarget", {wr_half_o, wr_idx_o}, expWr);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic doReset(input longint base, input longint top);
    resetn_a       = 1'b0;
    enable_i       = 1'b0;
    release_i      = 1'b0;
    release_half_i = 1'b0;
    axi.arready_i  = 1'b0;
    axi.rvalid_i   = 1'b0;
    axi.rresp_i    = 2'b00;
    axi.rlast_i    = 1'b0;
    base_addr_i    = AW'(base);
    top_addr_i     = AW'(top);
    arQ.delete();
    wrQ.delete();
    repeat (3) tick();
    checkOutput("rstArvalid", axi.arvalid_o, 64'd0);
    checkOutput("rstAraddr", axi.araddr_o, 64'd0);
    checkOutput("rstRready", axi.rready_o, 64'd0);
    checkOutput("rstWrEn", wr_en_o, 64'd0);
    checkOutput("rstFull", full_o, 64'd0);
    checkOutput("rstUnderrun", underrun_o, 64'd0);
    checkOutput("rstErr", err_o, 64'd0);
    resetn_a = 1'b1;
    mBase = base; mTop = top; mIdx = 0; mHalf = 1'b0; mFull = 2'b00;
    mUnder = 1'b0; mErr = 1'b0; mRetry = 0;
    repeat (2) tick();
  endtask

  // One full burst: AR handshake with random arready, 32 beats with random
  // gaps; optional error beat, misplaced rlast, release on the final beat,
  // and enable drop at a chosen beat.
  task automatic applyStimulus(input int errIdx, input int rlastIdx, input int relHalf, input int dropBeat);
    bit       hs;
    bit       rv;
    bit       burstHalf;
    bit       commit;
    bit       dropped;
    bit [1:0] preFull;
    int       waitCnt;
    int       beat;
    burstHalf = mHalf;
    dropped   = 1'b0;
    arQ.push_back(modelAddr());
    for (int i = 0; i < BL; i++) begin
      if (i != errIdx) wrQ.push_back({burstHalf, 5'(i)});
    end
    hs = 1'b0;
    waitCnt = 0;
    while (!hs && waitCnt < 60) begin
      axi.arready_i = (waitCnt > 4) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk_a);
      hs = axi.arvalid_o && axi.arready_i;
      tick();
      waitCnt++;
    end
    axi.arready_i = 1'b0;
    if (!hs) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL arTimeout: got no AR handshake expected addr 0x%0h", modelAddr());
      arQ.delete();
      wrQ.delete();
      return;
    end
    beat = 0;
    waitCnt = 0;
    while (beat < BL && waitCnt < 400) begin
      rv = ($urandom_range(0, 3) != 0);
      axi.rvalid_i   = rv;
      axi.rresp_i    = rv ? ((beat == errIdx) ? 2'b10 : 2'b00) : 2'($urandom_range(0, 3));
      axi.rlast_i    = rv ? (beat == rlastIdx) : 1'($urandom_range(0, 1));
      release_i      = rv && (beat == BL - 1) && (relHalf >= 0);
      release_half_i = (relHalf == 1);
      if (beat == dropBeat) begin
        enable_i = 1'b0;
        dropped  = 1'b1;
      end
      @(negedge clk_a);
      if (waitCnt == 0) checkOutput("rreadyLatency", axi.rready_o, 64'd1);
      hs = axi.rvalid_i && axi.rready_o;
      tick();
      waitCnt++;
      if (hs) beat++;
    end
    axi.rvalid_i = 1'b0;
    axi.rlast_i  = 1'b0;
    axi.rresp_i  = 2'b00;
    release_i    = 1'b0;
    if (beat < BL) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL beatTimeout: got %0d beats expected %0d", beat, BL);
    end
    if (errIdx >= 0 || rlastIdx != BL - 1) mErr = 1'b1;
    commit = 1'b1;
`ifdef VGA_FETCH_RETRY_EN
    if (errIdx >= 0 && mRetry < 3) begin
      commit = 1'b0;
      mRetry++;
    end else begin
      mRetry = 0;
    end
`endif
    preFull = mFull;
    if (commit) mFull[burstHalf] = 1'b1;
    if (relHalf >= 0) begin
      if (!preFull[relHalf]) mUnder = 1'b1;
      if (!(commit && (burstHalf == 1'(relHalf)))) mFull[relHalf] = 1'b0;
    end
    if (commit) begin
      mHalf = ~mHalf;
      mIdx++;
    end
    if (dropped) begin
      repeat (2) tick();
      mFull = 2'b00; mHalf = 1'b0; mIdx = 0; mRetry = 0;
    end
    checkOutput("fullAfterBurst", full_o, 64'(mFull));
    checkOutput("errAfterBurst", err_o, 64'(mErr));
    checkOutput("underrunAfterBurst", underrun_o, 64'(mUnder));
  endtask

  task automatic doRelease(input bit h);
    if (!mFull[h]) mUnder = 1'b1;
    mFull[h] = 1'b0;
    release_i      = 1'b1;
    release_half_i = h;
    tick();
    release_i = 1'b0;
    checkOutput("fullAfterRelease", full_o, 64'(mFull));
    checkOutput("underrunAfterRelease", underrun_o, 64'(mUnder));
  endtask

  task automatic randomStep();
    int e;
    int l;
    int r;
    if (!mFull[mHalf]) begin
      e = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, BL - 1)) : -1;
      l = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, BL - 1)) : BL - 1;
      r = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1)) : -1;
      applyStimulus(e, l, r, -1);
    end else begin
      doRelease(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    bit sawAR;
    resetn_a = 1'b0;

    // Frame walk with wrap and the enable-to-arvalid latency.
    doReset(64'h1000, 64'h1400);
    enable_i = 1'b1;
    @(negedge clk_a);
    checkOutput("arvalidBeforeSample", axi.arvalid_o, 64'd0);
    @(negedge clk_a);
    checkOutput("arvalidAfterSample", axi.arvalid_o, 64'd1);
    tick();
    applyStimulus(-1, BL - 1, -1, -1);
    applyStimulus(-1, BL - 1, -1, -1);
    checkOutput("bothFull", full_o, 64'd3);
    sawAR = 1'b0;
    repeat (10) begin
      @(negedge clk_a);
      if (axi.arvalid_o) sawAR = 1'b1;
      tick();
    end
    checkOutput("noArWhenFull", sawAR, 64'd0);
    doRelease(1'b0);
    applyStimulus(-1, BL - 1, -1, -1);
    doRelease(1'b1);
    applyStimulus(-1, BL - 1, -1, -1);
    doRelease(1'b0);
    applyStimulus(-1, BL - 1, -1, -1);

    // Underrun on releasing an unfilled half, then an error beat at index 5.
    doReset(64'h1000, 64'h1400);
    enable_i = 1'b1;
    applyStimulus(-1, BL - 1, -1, -1);
    doRelease(1'b1);
    checkOutput("fullStays01", full_o, 64'd1);
    doReset(64'h1000, 64'h1400);
    enable_i = 1'b1;
    applyStimulus(5, BL - 1, -1, -1);
    checkOutput("errAfterRresp", err_o, 64'd1);
    repeat (8) randomStep();

    // Release of the half being filled on its final beat.
    doReset(64'h1000, 64'h1400);
    enable_i = 1'b1;
    applyStimulus(-1, BL - 1, 0, -1);
    checkOutput("sameCycleUnderrun", underrun_o, 64'd1);

    // Enable dropped mid-burst, then restart from base.
    doReset(64'h1000, 64'h1400);
    enable_i = 1'b1;
    applyStimulus(-1, BL - 1, -1, -1);
    applyStimulus(-1, BL - 1, -1, 10);
    checkOutput("fullClearedOnDisable", full_o, 64'd0);
    enable_i = 1'b1;
    applyStimulus(-1, BL - 1, -1, -1);

    // Early rlast at beat 30.
    applyStimulus(-1, 30, -1, -1);
    checkOutput("errEarlyRlast", err_o, 64'd1);

    // Randomized frame geometry and traffic.
    for (int k = 0; k < 2; k++) begin
      doReset(64'h20000 + longint'($urandom_range(0, 255)) * 8,
              64'h20000 + 64'h800 + longint'($urandom_range(1, 5)) * STEP - longint'($urandom_range(0, 31)) * 8);
      enable_i = 1'b1;
      repeat (20) randomStep();
    end

    repeat (5) tick();
    checkOutput("arQueueDrained", 64'(arQ.size()), 64'd0);
    checkOutput("wrQueueDrained", 64'(wrQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
